// File: rtl/exp_inverse_solver.sv
// exp_inverse_solver
//   Sequential inverse of the square / cube / factorial operator. It searches
//   candidates i = 0, 1, 2, ... one per clock. It returns the largest i with
//   f(i) <= value, plus an exact-hit flag and an out-of-range flag.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request, sampled only while busy=0
//   pcode  0=square, 1=cube, 2/3=factorial
//   value  target result, latched with start
//   busy   high while searching
//   done   one-cycle pulse when root/exact/err update
//   root   largest i with f(i) <= value
//   exact  f(root) == value
//   err    value exceeds f(imax)
//
// Optional feature
//   EXP_INV_TRACE_EN : when defined, a simulation-only $display reports each
//   err termination and each ignored start. Logic is identical either way.

module exp_inverse_solver #(
   parameter int unsigned IN_W  = 3,
   parameter int unsigned OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       pcode,
   input  logic [OUT_W-1:0] value,
   output logic             busy,
   output logic             done,
   output logic [IN_W-1:0]  root,
   output logic             exact,
   output logic             err
);

   // f(i) is formed at full width so that it is never truncated before comparison.
   localparam int unsigned FW   = OUT_W + IN_W;
   localparam int unsigned CMAX = (1 << IN_W) - 1;

   function automatic int unsigned cube_max();
      int unsigned m;
      m = 0;
      for (int unsigned i = 0; i <= CMAX; i++) begin
         if (i * i * i < (1 << OUT_W)) m = i;
      end
      return m;
   endfunction

   // f(0)=0 is deliberate; it matches the forward operator.
   function automatic int unsigned fact(int unsigned n);
      case (n)
         1:       return 1;
         2:       return 2;
         3:       return 6;
         4:       return 24;
         5:       return 120;
         default: return 0;
      endcase
   endfunction

   localparam int unsigned SQ_MAX = CMAX;
   localparam int unsigned CU_MAX = cube_max();
   localparam int unsigned FA_MAX = (CMAX < 5) ? CMAX : 5;

   typedef enum logic [0:0] {StIdle, StSearch} state_e;

   state_e             state_q, state_d;
   logic [1:0]         pcode_q, pcode_d;
   logic [OUT_W-1:0]   value_q, value_d;
   logic [IN_W-1:0]    cand_q, cand_d;
   logic [IN_W-1:0]    root_q, root_d;
   logic               exact_q, exact_d;
   logic               err_q, err_d;
   logic               done_q, done_d;

   logic [IN_W-1:0]    imax;
   logic [FW-1:0]      fval;
   logic [FW-1:0]      vext;
   logic               term_err;

   // Last candidate for the latched operator.
   always_comb begin
      imax = IN_W'(FA_MAX);
      case (pcode_q)
         2'd0:    imax = IN_W'(SQ_MAX);
         2'd1:    imax = IN_W'(CU_MAX);
         default: imax = IN_W'(FA_MAX);
      endcase
   end

   always_comb begin
      fval = '0;
      case (pcode_q)
         2'd0:    fval = FW'(cand_q) * FW'(cand_q);
         2'd1:    fval = FW'(cand_q) * FW'(cand_q) * FW'(cand_q);
         default: fval = FW'(fact(32'(cand_q)));
      endcase
   end

   assign vext = FW'(value_q);

   always_comb begin
      state_d  = state_q;
      pcode_d  = pcode_q;
      value_d  = value_q;
      cand_d   = cand_q;
      root_d   = root_q;
      exact_d  = exact_q;
      err_d    = err_q;
      done_d   = 1'b0;
      term_err = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               pcode_d = pcode;
               value_d = value;
               cand_d  = '0;
               state_d = StSearch;
            end
         end
         StSearch: begin
            if (fval == vext) begin
               root_d  = cand_q;
               exact_d = 1'b1;
               err_d   = 1'b0;
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (fval > vext) begin
               // cand_q > 0 here because f(0)=0 can never exceed value.
               root_d  = cand_q - IN_W'(1);
               exact_d = 1'b0;
               err_d   = 1'b0;
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (cand_q == imax) begin
               term_err = 1'b1;
               root_d   = cand_q;
               exact_d  = 1'b0;
               err_d    = 1'b1;
               done_d   = 1'b1;
               state_d  = StIdle;
            end else begin
               cand_d = cand_q + IN_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         pcode_q <= '0;
         value_q <= '0;
         cand_q  <= '0;
         root_q  <= '0;
         exact_q <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pcode_q <= pcode_d;
         value_q <= value_d;
         cand_q  <= cand_d;
         root_q  <= root_d;
         exact_q <= exact_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign busy  = (state_q == StSearch);
   assign done  = done_q;
   assign root  = root_q;
   assign exact = exact_q;
   assign err   = err_q;

`ifdef EXP_INV_TRACE_EN
   // Simulation-only trace; it drives nothing.
   always @(posedge clk) begin
      if (!rst && term_err) $display("in error! value=%0d pcode=%0d", value_q, pcode_q);
      if (!rst && start && busy) $display("start ignored");
   end
`endif

endmodule

// File: tb/tb_exp_inverse_solver.sv
// Self-checking bench for exp_inverse_solver: directed steps with a scoreboard
// of expected results that is popped when done pulses.

module tb_exp_inverse_solver;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] pcode;
   logic [7:0] value;
   logic       busy;
   logic       done;
   logic [2:0] root;
   logic       exact;
   logic       err;

   typedef struct {
      int root;
      int exact;
      int err;
      int lat;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   exp_inverse_solver #(.IN_W(3), .OUT_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .pcode (pcode),
      .value (value),
      .busy  (busy),
      .done  (done),
      .root  (root),
      .exact (exact),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
   endtask

   // Reference operator and inverse, written from the operator definitions.
   function automatic int ref_f(input int pc, input int i);
      int fa[6] = '{0, 1, 2, 6, 24, 120};
      if (pc == 0) return i * i;
      if (pc == 1) return i * i * i;
      return fa[i];
   endfunction

   function automatic exp_t ref_solve(input int pc, input int v);
      exp_t e;
      int   im;
      im = (pc == 0) ? 7 : (pc == 1) ? 6 : 5;
      for (int i = 0; i <= im; i++) begin
         if (ref_f(pc, i) == v) begin
            e = '{i, 1, 0, i + 1};
            return e;
         end
         if (ref_f(pc, i) > v) begin
            e = '{i - 1, 0, 0, i + 1};
            return e;
         end
      end
      e = '{im, 0, 1, im + 1};
      return e;
   endfunction

   // Drive start for one edge (the sampling edge); returns #1 after that edge.
   task automatic launch(input int pc, input int v);
      start = 1'b1;
      pcode = 2'(pc);
      value = 8'(v);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges until done is seen, bounded.
   task automatic wait_done(input string tag, output int edges);
      edges = 0;
      while (!done && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check({tag, " done seen"}, 32'(done), 1);
   endtask

   task automatic pop_compare(input string tag, input int lat);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, " scoreboard empty"}, 0, 1);
         return;
      end
      e = sb.pop_front();
      check({tag, " root"}, 32'(root), e.root);
      check({tag, " exact"}, 32'(exact), e.exact);
      check({tag, " err"}, 32'(err), e.err);
      check({tag, " latency"}, lat, e.lat);
      check({tag, " busy low at done"}, 32'(busy), 0);
   endtask

   task automatic run(input string tag, input int pc, input int v, input exp_t e);
      int lat;
      sb.push_back(e);
      launch(pc, v);
      check({tag, " busy"}, 32'(busy), 1);
      wait_done(tag, lat);
      pop_compare(tag, lat);
      @(posedge clk);
      #1;
      check({tag, " done one cycle"}, 32'(done), 0);
   endtask

   initial begin
      int   lat;
      int   seen;
      exp_t e;

      rst   = 1'b1;
      start = 1'b0;
      pcode = 2'd0;
      value = 8'd0;
      #1;
      check("reset busy", 32'(busy), 0);
      check("reset done", 32'(done), 0);
      check("reset root", 32'(root), 0);
      check("reset exact", 32'(exact), 0);
      check("reset err", 32'(err), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run("sq36",   0, 36,  '{6, 1, 0, 7});
      run("sq40",   0, 40,  '{6, 0, 0, 8});
      run("sq200",  0, 200, '{7, 0, 1, 8});
      run("cu200",  1, 200, '{5, 0, 0, 7});
      run("cu216",  1, 216, '{6, 1, 0, 7});
      run("cu250",  1, 250, '{6, 0, 1, 7});
      run("fa120",  2, 120, '{5, 1, 0, 6});
      run("fa121",  3, 121, '{5, 0, 1, 6});
      run("fa0",    2, 0,   '{0, 1, 0, 1});
      run("fa1",    2, 1,   '{1, 1, 0, 2});

      // Extra cases against the reference model.
      for (int k = 0; k < 8; k++) begin
         int pc;
         int v;
         pc = int'($urandom_range(0, 3));
         v  = int'($urandom_range(0, 255));
         run($sformatf("rnd%0d_p%0d_v%0d", k, pc, v), pc, v, ref_solve(pc, v));
      end

      // Start while busy is ignored; pcode/value changes have no effect.
      sb.push_back('{7, 1, 0, 8});
      launch(0, 49);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      start = 1'b1;
      pcode = 2'd1;
      value = 8'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("ignored start busy", 32'(busy), 1);
      wait_done("busy_start", lat);
      pop_compare("busy_start", lat + 3);

      // Start accepted in the done cycle.
      sb.push_back('{2, 1, 0, 3});
      launch(0, 4);
      check("back2back done dropped", 32'(done), 0);
      check("back2back busy", 32'(busy), 1);
      wait_done("back2back", lat);
      pop_compare("back2back", lat);
      @(posedge clk);
      #1;

      // Asynchronous reset mid-search.
      launch(0, 49);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b1;
      #1;
      check("mid rst busy", 32'(busy), 0);
      check("mid rst done", 32'(done), 0);
      check("mid rst root", 32'(root), 0);
      check("mid rst exact", 32'(exact), 0);
      check("mid rst err", 32'(err), 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check("no done after abort", seen, 0);
      run("after_rst", 0, 9, '{3, 1, 0, 4});

      check("scoreboard drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
